// File: rtl/lsu_mem_adapter_pkg.sv
// Shared types and constants for the load/store unit memory adapter.
package lsu_pkg;

  // Access size as encoded on req_size; SZ_X is the illegal encoding.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  // True for requests that must be rejected without touching memory.
  function automatic logic is_illegal(input size_e size, input logic [1:0] adr_lo);
    case (size)
      SZ_B:    is_illegal = 1'b0;
      SZ_H:    is_illegal = adr_lo[0];
      SZ_W:    is_illegal = (adr_lo != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_adapter_if.sv
// Pipeline request/response and cache bus signals of the LSU adapter.
interface lsu_mem_adapter_if #(
  parameter int unsigned xlen = 32
);
  // pipeline request
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [31:0]     req_adr;
  logic [xlen-1:0] req_wdata;
  // pipeline response
  logic            rsp_valid;
  logic            rsp_ready;
  logic [xlen-1:0] rsp_data;
  logic            rsp_error;
  // downstream cache
  logic            mem_r_v;
  logic            mem_w_v;
  logic [31:0]     mem_adr;
  logic [31:0]     mem_data;
  logic [3:0]      mem_strobe;
  logic [xlen-1:0] mem_resp;
  logic            mem_resp_valid;
  logic            mem_resp_error;

  // adapter view
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_adr, req_wdata,
    input  rsp_ready, mem_resp, mem_resp_valid, mem_resp_error,
    output req_ready, rsp_valid, rsp_data, rsp_error,
    output mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe
  );

  // pipeline + cache view
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_adr, req_wdata,
    output rsp_ready, mem_resp, mem_resp_valid, mem_resp_error,
    input  req_ready, rsp_valid, rsp_data, rsp_error,
    input  mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe
  );
endinterface

// File: rtl/lsu_mem_adapter_lane_align.sv
// Byte-lane steering: store strobe/shift and load extract/extend.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned xlen = 32
) (
  input  size_e           size_i,
  input  logic [1:0]      adr_lo_i,
  input  logic            unsigned_i,
  input  logic [xlen-1:0] wdata_i,
  input  logic [31:0]     rdata_i,
  output logic [3:0]      strobe_o,
  output logic [31:0]     wdata_o,
  output logic [xlen-1:0] rdata_o
);

  logic [3:0]  base_strobe;
  logic [31:0] lane;

  // Store side: size mask and data moved up to the addressed byte lane.
  always_comb begin
    case (size_i)
      SZ_B:    base_strobe = 4'b0001;
      SZ_H:    base_strobe = 4'b0011;
      SZ_W:    base_strobe = 4'b1111;
      default: base_strobe = 4'b0000;
    endcase
    strobe_o = base_strobe << adr_lo_i;
    wdata_o  = wdata_i[31:0] << {adr_lo_i, 3'b000};
  end

  // Load side: bring the addressed lane down, truncate, then extend.
  always_comb begin
    lane    = rdata_i >> {adr_lo_i, 3'b000};
    rdata_o = '0;
    case (size_i)
      SZ_B: begin
        rdata_o      = (!unsigned_i && lane[7]) ? {xlen{1'b1}} : {xlen{1'b0}};
        rdata_o[7:0] = lane[7:0];
      end
      SZ_H: begin
        rdata_o       = (!unsigned_i && lane[15]) ? {xlen{1'b1}} : {xlen{1'b0}};
        rdata_o[15:0] = lane[15:0];
      end
      SZ_W: begin
        rdata_o       = (!unsigned_i && lane[31]) ? {xlen{1'b1}} : {xlen{1'b0}};
        rdata_o[31:0] = lane;
      end
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Adapts single-outstanding pipeline loads/stores to a word-addressed cache port.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int unsigned xlen    = 32,
  parameter int unsigned timeout = DEFAULT_TIMEOUT
) (
  input logic          clk,
  input logic          rst_n,
  lsu_mem_adapter_if.slave bus
);

  localparam int unsigned CW = $clog2(timeout + 1);

  state_e          state_q;
  logic            req_we_q;
  size_e           size_q;
  logic            uns_q;
  logic [1:0]      adr_lo_q;
  logic [CW-1:0]   cnt_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            rsp_error_q;
  logic [xlen-1:0] rsp_data_q;
  logic            mem_r_v_q;
  logic            mem_w_v_q;
  logic [31:0]     mem_adr_q;
  logic [31:0]     mem_data_q;
  logic [3:0]      mem_strobe_q;

  size_e           al_size_d;
  logic [1:0]      al_adr_lo_d;
  logic            al_uns_d;
  logic [3:0]      al_strobe;
  logic [31:0]     al_wdata;
  logic [xlen-1:0] al_rdata;
  logic            req_illegal_d;

  // The single aligner serves the live request in IDLE (store lanes are
  // registered at acceptance) and the captured request afterwards (load extract).
  always_comb begin
    al_size_d     = (state_q == IDLE) ? size_e'(bus.req_size) : size_q;
    al_adr_lo_d   = (state_q == IDLE) ? bus.req_adr[1:0]      : adr_lo_q;
    al_uns_d      = (state_q == IDLE) ? bus.req_unsigned      : uns_q;
    req_illegal_d = is_illegal(size_e'(bus.req_size), bus.req_adr[1:0]);
  end

  lsu_lane_align #(.xlen(xlen)) u_align (
    .size_i     (al_size_d),
    .adr_lo_i   (al_adr_lo_d),
    .unsigned_i (al_uns_d),
    .wdata_i    (bus.req_wdata),
    .rdata_i    (bus.mem_resp[31:0]),
    .strobe_o   (al_strobe),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  // Transaction FSM with registered handshake and cache outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_we_q     <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      adr_lo_q     <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_data_q   <= '0;
      mem_r_v_q    <= 1'b0;
      mem_w_v_q    <= 1'b0;
      mem_adr_q    <= '0;
      mem_data_q   <= '0;
      mem_strobe_q <= '0;
    end else begin
      // cache outputs live for the ISSUE cycle only
      mem_r_v_q    <= 1'b0;
      mem_w_v_q    <= 1'b0;
      mem_adr_q    <= '0;
      mem_data_q   <= '0;
      mem_strobe_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_we_q    <= bus.req_we;
            size_q      <= size_e'(bus.req_size);
            uns_q       <= bus.req_unsigned;
            adr_lo_q    <= bus.req_adr[1:0];
            req_ready_q <= 1'b0;
            if (req_illegal_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state_q      <= ISSUE;
              mem_r_v_q    <= !bus.req_we;
              mem_w_v_q    <= bus.req_we;
              mem_adr_q    <= {bus.req_adr[31:2], 2'b00};
              mem_strobe_q <= al_strobe;
              mem_data_q   <= bus.req_we ? al_wdata : '0;
            end
          end
        end
        ISSUE: begin
          cnt_q <= '0;
          if (req_we_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
          end else if (bus.mem_resp_valid) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= bus.mem_resp_error;
            rsp_data_q  <= bus.mem_resp_error ? '0 : al_rdata;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= bus.mem_resp_error;
            rsp_data_q  <= bus.mem_resp_error ? '0 : al_rdata;
          end else if (cnt_q == CW'(timeout - 1)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.mem_r_v    = mem_r_v_q;
  assign bus.mem_w_v    = mem_w_v_q;
  assign bus.mem_adr    = mem_adr_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.mem_strobe = mem_strobe_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed self-checking bench for lsu_mem_adapter.
module tb_lsu_mem_adapter;

  localparam int unsigned TMO = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lsu_mem_adapter_if #(.xlen(32)) bus ();

  lsu_mem_adapter #(.xlen(32), .timeout(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // present a request for one accepting edge
  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] adr, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_adr      = adr;
    bus.req_wdata    = wd;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  task automatic take_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_cleared"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_req_ready_back"},    32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_we         = 1'b0;
    bus.req_size       = 2'b00;
    bus.req_unsigned   = 1'b0;
    bus.req_adr        = '0;
    bus.req_wdata      = '0;
    bus.rsp_ready      = 1'b0;
    bus.mem_resp       = '0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_error = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    chk("rst_rsp_data",  bus.rsp_data,       32'd0);
    chk("rst_mem_v",     {30'd0, bus.mem_r_v, bus.mem_w_v}, 32'd0);
    chk("rst_mem_adr",   bus.mem_adr,        32'd0);
    chk("rst_strobe",    32'(bus.mem_strobe), 32'd0);
    rst_n = 1'b1;
    tick();

    // stray cache answer while idle is ignored
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp       = 32'hDEADBEEF;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("idle_stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_stray_req_ready", 32'(bus.req_ready), 32'd1);

    // store byte to lane 3
    send(1'b1, 2'b00, 1'b0, 32'h0002_0003, 32'h0000_00A5);
    chk("st_b_mem_w_v",   32'(bus.mem_w_v),    32'd1);
    chk("st_b_mem_r_v",   32'(bus.mem_r_v),    32'd0);
    chk("st_b_mem_adr",   bus.mem_adr,         32'h0002_0000);
    chk("st_b_strobe",    32'(bus.mem_strobe), 32'b1000);
    chk("st_b_mem_data",  bus.mem_data,        32'hA500_0000);
    chk("st_b_req_ready", 32'(bus.req_ready),  32'd0);
    chk("st_b_rsp_early", 32'(bus.rsp_valid),  32'd0);
    tick();
    chk("st_b_mem_w_v_once", 32'(bus.mem_w_v), 32'd0);
    chk("st_b_mem_data_off", bus.mem_data,     32'd0);
    chk("st_b_rsp_valid",  32'(bus.rsp_valid), 32'd1);
    chk("st_b_rsp_error",  32'(bus.rsp_error), 32'd0);
    chk("st_b_rsp_data",   bus.rsp_data,       32'd0);
    take_rsp("st_b");

    // store half to upper lanes
    send(1'b1, 2'b01, 1'b0, 32'h0000_1002, 32'hFFFF_BEEF);
    chk("st_h_strobe",   32'(bus.mem_strobe), 32'b1100);
    chk("st_h_mem_data", bus.mem_data,        32'hBEEF_0000);
    chk("st_h_mem_adr",  bus.mem_adr,         32'h0000_1000);
    tick();
    take_rsp("st_h");

    // load half signed, answer in the third cycle after acceptance
    send(1'b0, 2'b01, 1'b0, 32'h0002_0002, 32'h0);
    chk("ld_hs_mem_r_v",  32'(bus.mem_r_v),    32'd1);
    chk("ld_hs_mem_w_v",  32'(bus.mem_w_v),    32'd0);
    chk("ld_hs_strobe",   32'(bus.mem_strobe), 32'b1100);
    chk("ld_hs_mem_adr",  bus.mem_adr,         32'h0002_0000);
    tick();
    chk("ld_hs_mem_r_v_once", 32'(bus.mem_r_v), 32'd0);
    tick();
    bus.mem_resp       = 32'h8001_0000;
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("ld_hs_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ld_hs_rsp_data",  bus.rsp_data,       32'hFFFF_8001);
    chk("ld_hs_rsp_error", 32'(bus.rsp_error), 32'd0);
    take_rsp("ld_hs");

    // same load, zero-extended
    send(1'b0, 2'b01, 1'b1, 32'h0002_0002, 32'h0);
    tick();
    tick();
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("ld_hu_rsp_data", bus.rsp_data, 32'h0000_8001);
    take_rsp("ld_hu");

    // load byte signed answered in the ISSUE cycle itself
    send(1'b0, 2'b00, 1'b0, 32'h0002_0001, 32'h0);
    bus.mem_resp       = 32'h0000_F700;
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("ld_b_issue_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ld_b_issue_rsp_data",  bus.rsp_data,       32'hFFFF_FFF7);
    take_rsp("ld_b");

    // cache error on a load returns zero data
    send(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    bus.mem_resp       = 32'h1234_5678;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_error = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_error = 1'b0;
    chk("ld_memerr_error", 32'(bus.rsp_error), 32'd1);
    chk("ld_memerr_data",  bus.rsp_data,       32'd0);
    take_rsp("ld_memerr");

    // misaligned word load: no memory access
    send(1'b0, 2'b10, 1'b0, 32'h0002_0001, 32'h0);
    chk("mis_w_mem_v",     {30'd0, bus.mem_r_v, bus.mem_w_v}, 32'd0);
    chk("mis_w_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("mis_w_rsp_error", 32'(bus.rsp_error), 32'd1);
    chk("mis_w_rsp_data",  bus.rsp_data,       32'd0);
    take_rsp("mis_w");

    // illegal size on an aligned store
    send(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h5555_5555);
    chk("ill_sz_mem_v",     {30'd0, bus.mem_r_v, bus.mem_w_v}, 32'd0);
    chk("ill_sz_rsp_error", 32'(bus.rsp_error), 32'd1);
    take_rsp("ill_sz");

    // word load, response held under backpressure for 5 cycles
    send(1'b0, 2'b10, 1'b0, 32'h0002_0004, 32'h0);
    bus.mem_resp       = 32'h1234_5678;
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid      = 1'b1;
      bus.mem_resp       = 32'hCAFE_F00D;
      bus.mem_resp_valid = (i == 2);
      tick();
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data",  bus.rsp_data,       32'h1234_5678);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid      = 1'b0;
    bus.mem_resp_valid = 1'b0;
    take_rsp("bp");

    // back-to-back: accept a store on the cycle right after the handshake
    send(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h0BAD_CAFE);
    chk("b2b_mem_w_v",  32'(bus.mem_w_v),    32'd1);
    chk("b2b_mem_data", bus.mem_data,        32'h0BAD_CAFE);
    chk("b2b_strobe",   32'(bus.mem_strobe), 32'b1111);
    tick();
    take_rsp("b2b");

    // timeout: no answer for TMO cycles after entering WAIT
    send(1'b0, 2'b10, 1'b0, 32'h0002_0000, 32'h0);
    tick();
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      tick();
      chk("tmo_not_yet", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    chk("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("tmo_rsp_error", 32'(bus.rsp_error), 32'd1);
    chk("tmo_rsp_data",  bus.rsp_data,       32'd0);
    take_rsp("tmo");

    // reset while waiting abandons the load; late answer is ignored
    send(1'b0, 2'b10, 1'b0, 32'h0002_0000, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk("rstw_req_ready_async", 32'(bus.req_ready), 32'd1);
    chk("rstw_rsp_valid_async", 32'(bus.rsp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.mem_resp       = 32'h7777_7777;
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("rstw_late_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstw_late_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("rstw_still_idle", 32'(bus.rsp_valid), 32'd0);

    // adapter still usable after the abandoned transaction
    send(1'b0, 2'b00, 1'b1, 32'h0002_0003, 32'h0);
    bus.mem_resp       = 32'h9A00_0000;
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("post_rst_ld_data", bus.rsp_data, 32'h0000_009A);
    take_rsp("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
